// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Grants in IDLE, gives the ALU one cycle in EXEC, and holds the result in RESP until the owner accepts it.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] data_operandA0,
  input  logic [WIDTH-1:0] data_operandB0,
  input  logic [WIDTH-1:0] data_operandA1,
  input  logic [WIDTH-1:0] data_operandB1,
  input  logic [OPW-1:0]   ctrl_ALUopcode0,
  input  logic [OPW-1:0]   ctrl_ALUopcode1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             overflow,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             win;
  logic             accept;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    win = (&req_valid) ? ~last_grant_q : req_valid[1];
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid[win]) begin
      req_ready[win] = 1'b1;
    end
    accept = |req_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = win;
          last_grant_d = win;
          opa_d        = win ? data_operandA1 : data_operandA0;
          opb_d        = win ? data_operandB1 : data_operandB0;
          op_d         = win ? ctrl_ALUopcode1 : ctrl_ALUopcode0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        ovf_d    = alu_overflow;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
    end
  end

  assign resp_valid   = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign data_result  = result_q;
  assign overflow     = ovf_q;
  assign alu_operandA = opa_q;
  assign alu_operandB = opb_q;
  assign alu_opcode   = op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioral ADD/OR ALU attached.
module tb_alu_share_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [4:0]  op0 = '0, op1 = '0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [31:0] data_result;
  logic        overflow;
  logic [31:0] alu_operandA, alu_operandB;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_overflow;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.WIDTH(32), .OPW(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .data_operandA0(a0), .data_operandB0(b0),
    .data_operandA1(a1), .data_operandB1(b1),
    .ctrl_ALUopcode0(op0), .ctrl_ALUopcode1(op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .data_result(data_result), .overflow(overflow),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  always #5 clock = ~clock;

  // Signed overflow on ADD: operands agree in sign, sum does not.
  always_comb begin
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      5'b00000: begin
        alu_result   = alu_operandA + alu_operandB;
        alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
      end
      5'b00011: alu_result = alu_operandA | alu_operandB;
      default:  alu_result = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    check("rst_data_result", data_result, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_alu_opA", alu_operandA, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single request: 8 OR 0xC
    a0 = 32'h8; b0 = 32'hC; op0 = 5'b00011; req_valid = 2'b01; resp_ready = 2'b01;
    #1;
    check("single_ready", {30'd0, req_ready}, 32'd1);
    cycle();
    req_valid = 2'b00;
    check("single_exec_ready", {30'd0, req_ready}, 32'd0);
    check("single_latched_A", alu_operandA, 32'h8);
    check("single_exec_rv", {30'd0, resp_valid}, 32'd0);
    cycle();
    check("single_rv", {30'd0, resp_valid}, 32'd1);
    check("single_result", data_result, 32'hC);
    check("single_ovf", {31'd0, overflow}, 32'd0);
    cycle();
    check("single_idle_rv", {30'd0, resp_valid}, 32'd0);
    req_valid = 2'b01;
    #1;
    check("single_idle_ready", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;

    // Tie from reset: requester 0 first, then requester 1 (1 OR 2)
    reset = 1'b1;
    #1;
    reset = 1'b0;
    a0 = 32'h5; b0 = 32'h6; op0 = 5'b00000;
    a1 = 32'h1; b1 = 32'h2; op1 = 5'b00011;
    req_valid = 2'b11; resp_ready = 2'b11;
    #1;
    check("tie_first_ready", {30'd0, req_ready}, 32'd1);
    cycle();
    check("tie_first_A", alu_operandA, 32'h5);
    cycle();
    check("tie_first_rv", {30'd0, resp_valid}, 32'd1);
    check("tie_first_result", data_result, 32'd11);
    cycle();
    check("tie_second_ready", {30'd0, req_ready}, 32'd2);
    cycle();
    check("tie_second_A", alu_operandA, 32'h1);
    check("tie_second_B", alu_operandB, 32'h2);
    cycle();
    check("tie_second_rv", {30'd0, resp_valid}, 32'd2);
    check("tie_second_result", data_result, 32'h3);
    cycle();

    // Round-robin: 6 back-to-back operations, accepts every 3rd cycle
    a0 = 32'h10; b0 = 32'h20; op0 = 5'b00000;
    a1 = 32'hF0; b1 = 32'h0F; op1 = 5'b00011;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d_ready", i), {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      cycle();
      check($sformatf("rr%0d_exec_ready", i), {30'd0, req_ready}, 32'd0);
      cycle();
      check($sformatf("rr%0d_rv", i), {30'd0, resp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d_result", i), data_result, (i % 2 == 0) ? 32'h30 : 32'hFF);
      check($sformatf("rr%0d_resp_ready", i), {30'd0, req_ready}, 32'd0);
      cycle();
    end

    // Backpressure: 0x7FFFFFFF + 1 with resp_ready[1] low for 4 cycles
    a1 = 32'h7FFF_FFFF; b1 = 32'h1; op1 = 5'b00000;
    req_valid = 2'b10; resp_ready = 2'b01;
    #1;
    check("bp_ready", {30'd0, req_ready}, 32'd2);
    cycle();
    req_valid = 2'b11;
    a1 = 32'hDEAD_BEEF;
    cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d_rv", k), {30'd0, resp_valid}, 32'd2);
      check($sformatf("bp%0d_result", k), data_result, 32'h8000_0000);
      check($sformatf("bp%0d_ovf", k), {31'd0, overflow}, 32'd1);
      check($sformatf("bp%0d_ready", k), {30'd0, req_ready}, 32'd0);
      check($sformatf("bp%0d_alu_A", k), alu_operandA, 32'h7FFF_FFFF);
      if (k < 3) cycle();
    end
    resp_ready = 2'b10;
    #1;
    check("bp_release_ready", {30'd0, req_ready}, 32'd0);
    cycle();
    check("bp_next_ready", {30'd0, req_ready}, 32'd1);
    check("bp_idle_rv", {30'd0, resp_valid}, 32'd0);

    // Reset mid-op: accept requester 0, then reset during EXEC
    cycle();
    check("rmid_exec_A", alu_operandA, 32'h10);
    reset = 1'b1;
    #1;
    check("rmid_rv", {30'd0, resp_valid}, 32'd0);
    check("rmid_result", data_result, 32'd0);
    check("rmid_ovf", {31'd0, overflow}, 32'd0);
    check("rmid_alu_A", alu_operandA, 32'd0);
    check("rmid_alu_B", alu_operandB, 32'd0);
    check("rmid_alu_op", {27'd0, alu_opcode}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rmid_tie_ready", {30'd0, req_ready}, 32'd1);

    // Withdrawal: requester 0 pulses valid during requester 1's RESP
    a1 = 32'h1; b1 = 32'h2; op1 = 5'b00011;
    req_valid = 2'b10; resp_ready = 2'b00;
    #1;
    check("wd_ready", {30'd0, req_ready}, 32'd2);
    cycle();
    req_valid = 2'b00;
    cycle();
    check("wd_rv", {30'd0, resp_valid}, 32'd2);
    req_valid = 2'b01;
    #1;
    check("wd_pulse_ready", {30'd0, req_ready}, 32'd0);
    cycle();
    req_valid = 2'b00;
    resp_ready = 2'b10;
    cycle();
    check("wd_idle_ready", {30'd0, req_ready}, 32'd0);
    check("wd_idle_rv", {30'd0, resp_valid}, 32'd0);
    cycle();
    check("wd_alu_A", alu_operandA, 32'h1);
    check("wd_alu_B", alu_operandB, 32'h2);
    check("wd_alu_op", {27'd0, alu_opcode}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and sequencer that shares one combinational 32-bit ALU between two requesters, such as a fetch-side address adder and the execute stage. It grants one request at a time using round-robin fairness. It latches the winner's operands and opcode onto the ALU, registers the result and overflow, and returns them on the winner's response port with a valid/ready handshake. The block sits between the requesters and the ALU and is the only driver of the ALU inputs.

## Interface
- WIDTH, 32, operand/result width
- OPW, 5, ALU opcode width
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  2  per-requester request valid; bit i = requester i
- req_ready  output  2  per-requester accept; at most one bit high
- data_operandA0, data_operandB0  input  WIDTH  requester 0 operands
- data_operandA1, data_operandB1  input  WIDTH  requester 1 operands
- ctrl_ALUopcode0, ctrl_ALUopcode1  input  OPW  requester opcodes, passed through uninterpreted
- resp_valid  output  2  per-requester response valid
- resp_ready  input  2  per-requester response accept
- data_result  output  WIDTH  registered ALU result, valid with resp_valid
- overflow  output  1  registered ALU overflow, valid with resp_valid
- alu_operandA, alu_operandB  output  WIDTH  to ALU, driven from latched registers
- alu_opcode  output  OPW  to ALU, driven from latched register
- alu_result  input  WIDTH  from combinational ALU
- alu_overflow  input  1  from combinational ALU

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE behaviour:
  - Winner w is computed combinationally.
  - If only one req_valid bit is set, that requester wins.
  - If both are set, the requester not equal to last_grant wins.
  - req_ready[w] = 1 only in IDLE.
  - On req_valid[w] & req_ready[w], latch w's operands and opcode into the ALU input registers, store owner = w, set last_grant = w, and go to EXEC.
- EXEC (exactly 1 cycle): the ALU settles on the latched inputs. At the end of the cycle, capture alu_result into data_result and alu_overflow into overflow, then go to RESP.
- RESP:
  - resp_valid[owner] = 1 and the other bit is 0.
  - data_result and overflow are held stable.
  - On resp_ready[owner], go to IDLE.
  - resp_ready on the non-owner bit is ignored.
- ALU input registers hold their last value in all states; they change only on an accept.
- Reset values: last_grant = 1, so requester 0 wins the first tie. req_ready = 0, resp_valid = 0, data_result = 0, overflow = 0, alu_operandA/B = 0, alu_opcode = 0, owner = 0.
- req_valid may deassert without a handshake; nothing is latched in that case.
- Requests arriving during EXEC or RESP get no ready and must be held by the requester.

## Timing
- Accept at edge k leads to:
  - EXEC during cycle k→k+1, result captured at edge k+1;
  - resp_valid high from after edge k+1;
  - with resp_ready already high, response handshake at edge k+2 and IDLE from after edge k+2.
- Minimum accept-to-accept interval is 3 cycles. Stall in RESP extends it by one cycle per cycle without resp_ready.
- req_ready is combinational from req_valid and state, with no registered delay.
- Asynchronous reset in EXEC or RESP aborts the operation:
  - all outputs go to reset values immediately, without waiting for a clock edge;
  - the pending response is dropped;
  - the requester must re-issue.
- Simultaneous response handshake and a new req_valid: no accept in that cycle, because the FSM is in RESP. The accept happens in the following IDLE cycle.

## Test plan
Benches use a behavioral ALU model with opcode 00011 = OR and 00000 = ADD.
- Single request: requester 0 sends A=0x0000_0008, B=0x0000_000C, op=00011, with resp_ready[0] high. Required: accept at edge 0, resp_valid[0] after edge 1, data_result=0x0000_000C, overflow=0, IDLE after edge 2.
- Tie from reset: both requesters valid, requester 1 sends 0x1 OR 0x2. Required: requester 0 granted first. Requester 1 is granted at the next IDLE with result 0x3 on resp_valid[1], and its operands stay stable until granted.
- Round-robin: both requesters valid continuously for 6 operations. Required: grant order 0,1,0,1,0,1, with accept edges exactly 3 cycles apart.
- Backpressure: requester 1 sends ADD 0x7FFF_FFFF + 0x1 with resp_ready[1] low for 4 cycles. Required: data_result=0x8000_0000 and overflow=1 held stable, req_ready=00 throughout, and next accept 1 cycle after resp_ready[1] rises.
- Reset mid-op: assert reset during EXEC. Required: resp_valid=00, data_result=0 and alu_* = 0 without a clock edge; after release, a tie grants requester 0.
- Withdrawal: req_valid[0] pulses for 1 cycle during RESP of requester 1 and drops before IDLE. Required: no accept, and alu_operandA/B are unchanged.
